led_fx_gen: RTL and testbench

LED_FX_GEN -- requirements
Module: led_fx_gen

---
 rtl/led_fx_pkg.sv | 13 +
 rtl/led_fx_prescaler.sv | 23 ++
 rtl/led_fx_gen.sv | 64 ++++++
 tb/tb_led_fx_gen.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/led_fx_pkg.sv
// led_fx_pkg: mode encodings, field widths and direction codes shared by the LED effect generator.
package led_fx_pkg;
  localparam int MODE_W = 2;
  localparam int PWM_W = 4;
  typedef enum logic [MODE_W-1:0] {
    MODE_BLINK    = 2'd0,
    MODE_ROT_L    = 2'd1,
    MODE_ROT_R    = 2'd2,
    MODE_PINGPONG = 2'd3
  } mode_e;
  localparam logic DIR_LEFT = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
endpackage

// File: rtl/led_fx_prescaler.sv
// led_fx_prescaler: divides enabled cycles by TICK_DIV into a one-cycle step pulse; clr restarts the count.
module led_fx_prescaler #(
  parameter int TICK_DIV = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic last;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  always_comb begin
    last = cnt_q == LAST;
    tick = ~reset & en & ~clr & last;
    cnt_d = clr ? '0 : !en ? cnt_q : last ? '0 : cnt_q + CW'(1);
  end
endmodule

// File: rtl/led_fx_gen.sv
// led_fx_gen: LED effect generator (blink, rotate left/right, ping-pong) stepped by a prescaler.
// Defining LED_FX_PWM_EN adds a 4-bit duty input that dims the outputs with a free-running PWM counter.
module led_fx_gen
  import led_fx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TICK_DIV = 25000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
`ifdef LED_FX_PWM_EN
  input  logic [PWM_W-1:0]  duty,
`endif
  output logic [WIDTH-1:0]  q_out,
  output logic              tick
);
  logic [MODE_W-1:0] mode_q, mode_d;
  logic [WIDTH-1:0] pattern_q, pattern_d, seed, stepped, pp;
  logic dir_q, dir_d, chg;
  assign chg = mode != mode_q;
  led_fx_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk(clk),
    .reset(reset),
    .en(en),
    .clr(chg),
    .tick(tick)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mode_q <= MODE_BLINK;
      pattern_q <= '0;
      dir_q <= DIR_LEFT;
    end else begin
      mode_q <= mode_d;
      pattern_q <= pattern_d;
      dir_q <= dir_d;
    end
  // A mode change reloads the new seed and overrides any step due on the same edge.
  always_comb begin
    mode_d = mode;
    seed = mode == MODE_BLINK ? '0 : mode == MODE_ROT_R ? {1'b1, {(WIDTH-1){1'b0}}} : WIDTH'(1);
    pp = dir_q ? pattern_q >> 1 : pattern_q << 1;
    stepped = mode_q == MODE_BLINK ? ~pattern_q :
              mode_q == MODE_ROT_L ? {pattern_q[WIDTH-2:0], pattern_q[WIDTH-1]} :
              mode_q == MODE_ROT_R ? {pattern_q[0], pattern_q[WIDTH-1:1]} : pp;
    pattern_d = chg ? seed : tick ? stepped : pattern_q;
    dir_d = chg ? DIR_LEFT :
            (tick && mode_q == MODE_PINGPONG) ? (pp[WIDTH-1] ? DIR_RIGHT : pp[0] ? DIR_LEFT : dir_q) : dir_q;
  end
`ifdef LED_FX_PWM_EN
  logic [PWM_W-1:0] pc_q, pc_d;
  always_ff @(posedge clk or posedge reset)
    if (reset) pc_q <= '0;
    else pc_q <= pc_d;
  always_comb begin
    pc_d = pc_q + PWM_W'(1);
    q_out = pattern_q & {WIDTH{pc_q < duty}};
  end
`else
  always_comb q_out = pattern_q;
`endif
endmodule

// File: tb/tb_led_fx_gen.sv
// tb_led_fx_gen: two generator instances (8-bit/div-4 and 4-bit/div-1) checked every cycle against a step-count model.
module tb_led_fx_gen;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en_a = 1'b0, en_b = 1'b1;
  logic [1:0] mode_a = 2'd0, mode_b = 2'd0;
  logic [7:0] q_a;
  logic [3:0] q_b;
  logic tick_a, tick_b;
`ifdef LED_FX_PWM_EN
  logic [3:0] duty = 4'd15;
`endif
  int total = 0, bad = 0;
  int m_mode[2], m_cnt[2], m_steps[2];
  int m_pc = 0;
  int td[2] = '{4, 1};
  int found;
  logic [3:0] pp_seq[8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};
  logic [3:0] rr_seq[5] = '{4'h8, 4'h4, 4'h2, 4'h1, 4'h8};

  always #5 clk = ~clk;

  led_fx_gen #(.WIDTH(8), .TICK_DIV(4)) dut_a (
    .clk(clk), .reset(reset), .en(en_a), .mode(mode_a),
`ifdef LED_FX_PWM_EN
    .duty(duty),
`endif
    .q_out(q_a), .tick(tick_a)
  );
  led_fx_gen #(.WIDTH(4), .TICK_DIV(1)) dut_b (
    .clk(clk), .reset(reset), .en(en_b), .mode(mode_b),
`ifdef LED_FX_PWM_EN
    .duty(duty),
`endif
    .q_out(q_b), .tick(tick_b)
  );

  // Pattern as a pure function of the mode and the number of steps taken since its seed.
  function automatic int model_pat(int w, int md, int st);
    int s;
    case (md)
      0: return (st % 2) ? (1 << w) - 1 : 0;
      1: return 1 << (st % w);
      2: return 1 << (w - 1 - st % w);
      default: begin
        s = st % (2 * w - 2);
        return 1 << (s < w ? s : 2 * w - 2 - s);
      end
    endcase
  endfunction

  function automatic logic [31:0] gate(logic [31:0] v);
`ifdef LED_FX_PWM_EN
    return m_pc < int'(duty) ? v : 32'd0;
`else
    return v;
`endif
  endfunction

  function automatic logic exp_tick(int d, logic e, logic [1:0] md);
    return !reset && e && int'(md) == m_mode[d] && m_cnt[d] == td[d] - 1;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step_model(int d, logic e, logic [1:0] md);
    if (int'(md) != m_mode[d]) begin
      m_mode[d] = md;
      m_cnt[d] = 0;
      m_steps[d] = 0;
    end else if (e) begin
      if (m_cnt[d] == td[d] - 1) begin
        m_cnt[d] = 0;
        m_steps[d]++;
      end else m_cnt[d]++;
    end
  endtask

  always @(posedge clk or posedge reset)
    if (reset) begin
      m_mode = '{0, 0};
      m_cnt = '{0, 0};
      m_steps = '{0, 0};
      m_pc = 0;
    end else begin
      m_pc = (m_pc + 1) % 16;
      step_model(0, en_a, mode_a);
      step_model(1, en_b, mode_b);
    end

  always @(negedge clk) begin
    chk("q_a", q_a, gate(model_pat(8, m_mode[0], m_steps[0])));
    chk("tick_a", tick_a, exp_tick(0, en_a, mode_a));
    chk("q_b", q_b, gate(model_pat(4, m_mode[1], m_steps[1])));
    chk("tick_b", tick_b, exp_tick(1, en_b, mode_b));
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    cyc(3);
    chk("rst_q_a", q_a, 0);
    chk("rst_tick_b", tick_b, 0);
    reset = 1'b0; en_a = 1'b1; mode_a = 2'd1; #1;
    chk("blink0", q_b, gate(0));
    chk("tick_b_div1", tick_b, 1);
    cyc(1); chk("blink1", q_b, gate('hF)); chk("rotl_seed", q_a, gate('h01));
    cyc(1); chk("blink2", q_b, gate(0));
    cyc(1); chk("blink3", q_b, gate('hF));
    cyc(2); chk("rotl_step1", q_a, gate('h02));
    mode_b = 2'd3; cyc(1);
    for (int i = 0; i < 8; i++) begin
      chk("pingpong_w4", q_b, gate(pp_seq[i]));
      cyc(1);
    end
    mode_b = 2'd2; cyc(1);
    for (int i = 0; i < 5; i++) begin
      chk("rotr_w4", q_b, gate(rr_seq[i]));
      cyc(1);
    end
    found = 0;
    for (int i = 0; i < 16 && found == 0; i++)
      if (tick_a) found = 1; else cyc(1);
    chk("tick_seen", found, 1);
    mode_a = 2'd2; #1;
    chk("tick_suppressed", tick_a, 0);
    cyc(1); chk("rotr_reload", q_a, gate('h80));
    en_a = 1'b0; cyc(10); chk("frozen", q_a, gate('h80));
    en_a = 1'b1; mode_a = 2'd3;
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++)
      if (q_a == 8'h20) found = 1; else cyc(1);
    chk("pp_bit5_seen", found, 1);
    reset = 1'b1; #1;
    chk("rst_async", q_a, 0);
    cyc(1); reset = 1'b0;
    cyc(1); chk("pp_after_rst", q_a, gate('h01));
    cyc(4); chk("pp_dir_left", q_a, gate('h02));
`ifdef LED_FX_PWM_EN
    mode_a = 2'd0; duty = 4'd4; cyc(40);
    duty = 4'd0; cyc(20);
    duty = 4'd15;
`endif
    repeat (3000) begin
      if ($urandom_range(0, 15) == 0) mode_a = 2'($urandom);
      if ($urandom_range(0, 15) == 0) mode_b = 2'($urandom);
      en_a = $urandom_range(0, 3) != 0;
      en_b = $urandom_range(0, 3) != 0;
      reset = $urandom_range(0, 299) == 0;
`ifdef LED_FX_PWM_EN
      if ($urandom_range(0, 63) == 0) duty = 4'($urandom);
`endif
      cyc(1);
    end
    reset = 1'b0;
    cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
